// File: rtl/mem_agen_pipe.sv
// Address-generation pipe for load/store ops: effective address and misalignment in stage 1,
// then NUM_STAGES-1 plain shift stages, then a skid FIFO toward the LSU.
module mem_agen_pipe #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 64,
    parameter int IMM_W          = 32,
    parameter int TAG_W          = 24,
    parameter int NUM_STAGES     = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int MISALIGN_CHECK = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             recoverFlag_i,
    input  logic                             exceptionFlag_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DATA_W-1:0]                src1Data_i,
    input  logic [DATA_W-1:0]                src2Data_i,
    input  logic [IMM_W-1:0]                 imm_i,
    input  logic                             ldSt_i,
    input  logic [1:0]                       size_i,
    input  logic [TAG_W-1:0]                 tag_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [ADDR_W-1:0]                outAddr_o,
    output logic [DATA_W-1:0]                outData_o,
    output logic                             outLdSt_o,
    output logic [1:0]                       outSize_o,
    output logic [TAG_W-1:0]                 outTag_o,
    output logic                             outMisalign_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  credits_o
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ldSt;
        logic [1:0]        size;
        logic [TAG_W-1:0]  tag;
        logic              misalign;
    } opT;

    // Handshake: a beat moves on a rising edge where valid and ready are both high. Neither
    // valid depends on the matching ready; in_ready_o is a pure credit check, so an accepted
    // op always has a FIFO slot reserved and the stages never stall.
    logic flush;
    logic accept;
    logic push;
    logic pop;

    assign flush  = recoverFlag_i | exceptionFlag_i;
    assign accept = in_valid_i & in_ready_o;

    // Stage-1 address computation
    logic signed [IMM_W-1:0] immSigned;
    logic [DATA_W-1:0]       immExt;
    logic [DATA_W-1:0]       sum;
    logic [ADDR_W-1:0]       effAddr;
    logic                    misalign;
    opT                      newOp;

    always_comb begin
        immSigned = imm_i;
        immExt    = DATA_W'(immSigned);
        sum       = src1Data_i + immExt;
        effAddr   = sum[ADDR_W-1:0];
        misalign  = 1'b0;
        case (size_i)
            2'd1:    misalign = effAddr[0];
            2'd2:    misalign = |effAddr[1:0];
            2'd3:    misalign = |effAddr[2:0];
            default: misalign = 1'b0;
        endcase
        if (MISALIGN_CHECK == 0) begin
            misalign = 1'b0;
        end
        newOp.addr     = effAddr;
        newOp.data     = src2Data_i;
        newOp.ldSt     = ldSt_i;
        newOp.size     = size_i;
        newOp.tag      = tag_i;
        newOp.misalign = misalign;
    end

    // Stage registers: only the valid bits are reset
    logic [NUM_STAGES-1:0] stgValid;
    opT                    stg [NUM_STAGES];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stgValid <= '0;
        end else begin
            stgValid[0] <= accept;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stgValid[k] <= stgValid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            stg[0] <= newOp;
        end
        for (int k = 1; k < NUM_STAGES; k++) begin
            stg[k] <= stg[k-1];
        end
    end

    // Skid FIFO; pointers wrap explicitly so non-power-of-2 depths work
    opT                fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CRED_W-1:0] fifoCount;
    opT                headOp;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = stgValid[NUM_STAGES-1];
    assign pop  = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                tailPtr <= nextPtr(tailPtr);
            end
            if (pop) begin
                headPtr <= nextPtr(headPtr);
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + CRED_W'(1);
            end else if (pop && !push) begin
                fifoCount <= fifoCount - CRED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[tailPtr] <= stg[NUM_STAGES-1];
        end
    end

    // Credits cover both FIFO entries and ops still travelling through the stages
    int inflight;
    int credInt;

    always_comb begin
        inflight = 0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (stgValid[k]) begin
                inflight = inflight + 1;
            end
        end
        credInt   = FIFO_DEPTH - int'(fifoCount) - inflight;
        credits_o = CRED_W'(credInt);
    end

    assign in_ready_o = (credits_o != '0) & ~reset & ~flush;

    // Head outputs read zero whenever nothing valid is presented, including during reset
    assign headOp        = fifoMem[headPtr];
    assign out_valid_o   = (fifoCount != '0) & ~reset;
    assign outAddr_o     = out_valid_o ? headOp.addr : '0;
    assign outData_o     = out_valid_o ? headOp.data : '0;
    assign outLdSt_o     = out_valid_o & headOp.ldSt;
    assign outSize_o     = out_valid_o ? headOp.size : 2'd0;
    assign outTag_o      = out_valid_o ? headOp.tag : '0;
    assign outMisalign_o = out_valid_o & headOp.misalign;

endmodule

// File: tb/tb_mem_agen_pipe.sv
// Bench for mem_agen_pipe: dut 0 is the default configuration, dut 1 uses a 2-entry FIFO
// with misalignment detection disabled. A negedge scoreboard tracks every op of both.
module tb_mem_agen_pipe;

    localparam int NS      = 2;
    localparam int DEPTH_A = 4;
    localparam int DEPTH_B = 2;
    localparam int EW      = 64 + 64 + 1 + 2 + 24 + 1;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
        $fatal(1);
    end

    // ---------------- shared stimulus, per-dut handshakes ----------------
    logic        recover, exception;
    logic [63:0] src1, src2;
    logic [31:0] imm;
    logic        ld_st;
    logic [1:0]  size;
    logic [23:0] tag;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_addr  [2];
    logic [63:0] out_data  [2];
    logic        out_ld_st [2];
    logic [1:0]  out_size  [2];
    logic [23:0] out_tag   [2];
    logic        out_mis   [2];
    logic [2:0]  cred_a;
    logic [1:0]  cred_b;

    mem_agen_pipe #(.NUM_STAGES(NS), .FIFO_DEPTH(DEPTH_A), .MISALIGN_CHECK(1)) dut_a (
        .clk(clk), .reset(reset), .recoverFlag_i(recover), .exceptionFlag_i(exception),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .src1Data_i(src1), .src2Data_i(src2), .imm_i(imm), .ldSt_i(ld_st), .size_i(size), .tag_i(tag),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .outAddr_o(out_addr[0]), .outData_o(out_data[0]), .outLdSt_o(out_ld_st[0]),
        .outSize_o(out_size[0]), .outTag_o(out_tag[0]), .outMisalign_o(out_mis[0]),
        .credits_o(cred_a)
    );

    mem_agen_pipe #(.NUM_STAGES(NS), .FIFO_DEPTH(DEPTH_B), .MISALIGN_CHECK(0)) dut_b (
        .clk(clk), .reset(reset), .recoverFlag_i(recover), .exceptionFlag_i(exception),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .src1Data_i(src1), .src2Data_i(src2), .imm_i(imm), .ldSt_i(ld_st), .size_i(size), .tag_i(tag),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .outAddr_o(out_addr[1]), .outData_o(out_data[1]), .outLdSt_o(out_ld_st[1]),
        .outSize_o(out_size[1]), .outTag_o(out_tag[1]), .outMisalign_o(out_mis[1]),
        .credits_o(cred_b)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;
    int pop_cnt [2];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int            rdy_q0[$];
    int            rdy_q1[$];

    // Reference: address is src1 plus the sign-extended immediate; alignment follows access size.
    function automatic logic [EW-1:0] make_exp(input int d);
        logic [63:0] s;
        logic        m;
        s = src1 + {{32{imm[31]}}, imm};
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = (s % 2) != 0;
            2'd2:    m = (s % 4) != 0;
            default: m = (s % 8) != 0;
        endcase
        if (d == 1) m = 1'b0;
        return {s, src2, ld_st, size, tag, m};
    endfunction

    task automatic mon_step(input int d);
        int            depth, qs, rdy0;
        logic          fl, want_v, want_r;
        logic [2:0]    cred_got;
        logic [EW-1:0] got, want;
        depth    = (d == 0) ? DEPTH_A : DEPTH_B;
        qs       = (d == 0) ? exp_q0.size() : exp_q1.size();
        rdy0     = 0;
        if (qs > 0) rdy0 = (d == 0) ? rdy_q0[0] : rdy_q1[0];
        fl       = recover | exception;
        want_v   = !reset && (qs > 0) && (rdy0 <= cyc);
        want_r   = !reset && !fl && (qs < depth);
        cred_got = (d == 0) ? cred_a : {1'b0, cred_b};

        checks++;
        if (cred_got !== 3'(depth - qs)) begin
            failures++;
            $display("FAIL credits dut%0d cyc%0d: got %0d required %0d", d, cyc, cred_got, depth - qs);
        end
        checks++;
        if (in_ready[d] !== want_r) begin
            failures++;
            $display("FAIL in_ready dut%0d cyc%0d: got %b required %b", d, cyc, in_ready[d], want_r);
        end
        checks++;
        if (out_valid[d] !== want_v) begin
            failures++;
            $display("FAIL out_valid dut%0d cyc%0d: got %b required %b", d, cyc, out_valid[d], want_v);
        end
        got = {out_addr[d], out_data[d], out_ld_st[d], out_size[d], out_tag[d], out_mis[d]};
        if (reset) begin
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h required 0", d, got);
            end
        end
        if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
            checks++;
            if (qs == 0) begin
                failures++;
                $display("FAIL pop dut%0d cyc%0d: got op %h with nothing outstanding", d, cyc, got);
            end else begin
                want = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (d == 0) void'(rdy_q0.pop_front()); else void'(rdy_q1.pop_front());
                pop_cnt[d]++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL pop_data dut%0d cyc%0d: got %h required %h", d, cyc, got, want);
                end
            end
        end
        if (in_valid[d] === 1'b1 && in_ready[d] === 1'b1) begin
            if (d == 0) begin exp_q0.push_back(make_exp(0)); rdy_q0.push_back(cyc + 1 + NS); end
            else        begin exp_q1.push_back(make_exp(1)); rdy_q1.push_back(cyc + 1 + NS); end
        end
        if (reset || fl) begin
            if (d == 0) begin exp_q0.delete(); rdy_q0.delete(); end
            else        begin exp_q1.delete(); rdy_q1.delete(); end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0);
            mon_step(1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [63:0] s1, input logic [31:0] im, input logic [1:0] sz,
                        input logic ls, input logic [23:0] tg, input logic [63:0] sd, output int waits);
        bit acc;
        src1 = s1; imm = im; size = sz; ld_st = ls; tag = tg; src2 = sd;
        in_valid[d] = 1'b1;
        waits = 0;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = (in_ready[d] === 1'b1);
            step();
            if (acc) break;
            waits++;
        end
        in_valid[d] = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout dut%0d: got no accept in %0d cycles required accept", d, waits);
        end
    endtask

    task automatic send_rand(input int d, output int waits);
        send(d, {$urandom, $urandom}, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             24'($urandom), {$urandom, $urandom}, waits);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        mon_en = 1;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got ready=%b valid=%b required 0 0", in_ready[0], out_valid[0]);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cred_a !== 3'd4 || cred_b !== 2'd2 || in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got cred_a=%0d cred_b=%0d ready=%b required 4 2 1", cred_a, cred_b, in_ready[0]);
        end
        step();
    endtask

    task automatic run_latency_op(input logic [23:0] tg);
        int w;
        out_ready[0] = 1'b1;
        send(0, 64'h1000, 32'hFFFF_FFF8, 2'd3, 1'b0, tg, 64'h55, w);
        for (int c = 1; c <= NS + 1; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== (c == NS + 1)) begin
                failures++;
                $display("FAIL latency cycle%0d: got valid=%b required %b", c, out_valid[0], c == NS + 1);
            end
            if (c == NS + 1) begin
                checks++;
                if (out_addr[0] !== 64'hFF8 || out_mis[0] !== 1'b0 || out_tag[0] !== tg || out_size[0] !== 2'd3) begin
                    failures++;
                    $display("FAIL latency_fields: got addr=%h mis=%b tag=%h size=%0d required ff8 0 %h 3",
                             out_addr[0], out_mis[0], out_tag[0], out_size[0], tg);
                end
            end
            step();
        end
    endtask

    task automatic test_basic();
        run_latency_op(24'hABCDE);
    endtask

    int b2b_wait, b2b_run, b2b_best;

    task automatic test_back_to_back();
        int start;
        out_ready[0] = 1'b1;
        b2b_wait = 0; b2b_run = 0; b2b_best = 0;
        start = pop_cnt[0];
        fork
            begin
                int w;
                for (int i = 0; i < 8; i++) begin send_rand(0, w); b2b_wait += w; end
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid[0] === 1'b1) begin
                        b2b_run++;
                        if (b2b_run > b2b_best) b2b_best = b2b_run;
                    end else b2b_run = 0;
                end
            end
        join
        step();
        checks++;
        if (b2b_wait != 0 || b2b_best != 8 || pop_cnt[0] - start != 8) begin
            failures++;
            $display("FAIL back_to_back: got waits=%0d run=%0d pops=%0d required 0 8 8", b2b_wait, b2b_best, pop_cnt[0] - start);
        end
    endtask

    task automatic test_shallow();
        int w, total, start;
        out_ready[1] = 1'b1;
        total = 0;
        start = pop_cnt[1];
        for (int i = 0; i < 8; i++) begin send_rand(1, w); total += w; end
        repeat (10) step();
        checks++;
        if (total == 0 || pop_cnt[1] - start != 8 || exp_q1.size() != 0) begin
            failures++;
            $display("FAIL shallow: got stalls=%0d pops=%0d left=%0d required >0 8 0", total, pop_cnt[1] - start, exp_q1.size());
        end
    endtask

    task automatic test_backpressure();
        int w, total, start;
        out_ready[0] = 1'b0;
        total = 0;
        for (int i = 0; i < 4; i++) begin send_rand(0, w); total += w; end
        @(negedge clk);
        checks++;
        if (total != 0 || cred_a !== 3'd0 || in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got stalls=%0d credits=%0d ready=%b required 0 0 0", total, cred_a, in_ready[0]);
        end
        step();
        src1 = {$urandom, $urandom};
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall: got ready=%b required 0", in_ready[0]);
            end
            step();
        end
        in_valid[0] = 1'b0;
        start = pop_cnt[0];
        out_ready[0] = 1'b1;
        repeat (8) step();
        @(negedge clk);
        checks++;
        if (pop_cnt[0] - start != 4 || cred_a !== 3'd4) begin
            failures++;
            $display("FAIL bp_drain: got pops=%0d credits=%0d required 4 4", pop_cnt[0] - start, cred_a);
        end
        step();
    endtask

    localparam int          MIS_N = 8;
    localparam int          T_D   [MIS_N] = '{0, 0, 0, 0, 1, 0, 0, 1};
    localparam logic [63:0] T_S1  [MIS_N] = '{64'h1002, 64'h1002, 64'h1003, 64'h1001,
                                              64'h1001, 64'h1007, 64'h1006, 64'h1002};
    localparam logic [31:0] T_IMM [MIS_N] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                              32'h0, 32'hFFFF_FFFD, 32'h0, 32'h0};
    localparam logic [1:0]  T_SZ  [MIS_N] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2};
    localparam logic        T_MIS [MIS_N] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_misalign();
        int  w, d;
        bit  found;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        for (int i = 0; i < MIS_N; i++) begin
            d = T_D[i];
            send(d, T_S1[i], T_IMM[i], T_SZ[i], 1'b1, 24'(i), 64'(i), w);
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                if (out_valid[d] === 1'b1) begin
                    found = 1;
                    checks++;
                    if (out_mis[d] !== T_MIS[i]) begin
                        failures++;
                        $display("FAIL misalign case%0d: got %b required %b", i, out_mis[d], T_MIS[i]);
                    end
                end
                step();
            end
            if (!found) begin
                checks++;
                failures++;
                $display("FAIL misalign_timeout case%0d: got no output required one", i);
            end
        end
    endtask

    task automatic test_flush();
        int w, spurious, start;
        // recovery with ops in FIFO and both stages, plus an input in the flush cycle
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(0, w);
        recover = 1'b1;
        src1 = 64'hDEAD; in_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle: got ready=%b valid=%b required 0 1", in_ready[0], out_valid[0]);
        end
        step();
        recover = 1'b0; in_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || cred_a !== 3'd4) begin
            failures++;
            $display("FAIL flush_after: got valid=%b credits=%0d required 0 4", out_valid[0], cred_a);
        end
        step();
        out_ready[0] = 1'b1;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) spurious++;
            step();
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL flush_ghost: got %0d valid cycles required 0", spurious);
        end
        // exception flush coinciding with a pop: the popped op still counts as delivered
        start = pop_cnt[0];
        for (int i = 0; i < 3; i++) send_rand(0, w);
        exception = 1'b1;
        step();
        exception = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || cred_a !== 3'd4 || pop_cnt[0] - start != 1) begin
            failures++;
            $display("FAIL exc_flush: got valid=%b credits=%0d pops=%0d required 0 4 1",
                     out_valid[0], cred_a, pop_cnt[0] - start);
        end
        step();
    endtask

    task automatic test_reset_midop();
        int w;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(0, w);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_addr[0] !== 64'h0) begin
            failures++;
            $display("FAIL midop_reset: got ready=%b valid=%b addr=%h required 0 0 0", in_ready[0], out_valid[0], out_addr[0]);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || cred_a !== 3'd4) begin
            failures++;
            $display("FAIL midop_after: got valid=%b credits=%0d required 0 4", out_valid[0], cred_a);
        end
        step();
        run_latency_op(24'h13579);
    endtask

    initial begin
        reset = 1'b1; recover = 1'b0; exception = 1'b0;
        src1 = '0; src2 = '0; imm = '0; ld_st = 1'b0; size = 2'd0; tag = '0;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        out_ready[0] = 1'b0; out_ready[1] = 1'b0;
        pop_cnt[0] = 0; pop_cnt[1] = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_shallow();
        test_backpressure();
        test_misalign();
        test_flush();
        test_reset_midop();
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
